// File: rtl/fifo_rd_consumer.sv
// Read-side FIFO consumer: pops show-ahead words, checks them against the i*STEP ROM pattern, forwards them.
// One cycle pop-to-output latency; pops only while the one-entry output register can accept, so out_ready stalls the FIFO.
module fifo_rd_consumer #(
    parameter int DATA_W    = 8,
    parameter int STEP      = 4,
    parameter int NUM_WORDS = 128,
    parameter int CNT_W     = 8
) (
    input  logic              clk_rd,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              mismatch
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pop;
    logic              last_pop;
    logic              clr;
    logic [DATA_W-1:0] expected;

    assign pop      = (state == RUN) & ~rd_empty & (~out_valid | out_ready);
    assign rd_en    = pop;
    assign last_pop = pop & (word_cnt == CNT_W'(NUM_WORDS - 1));
    // start only takes effect outside RUN, which is also when counters restart
    assign clr      = (state != RUN) & start;

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_pop) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            mismatch      <= 1'b0;
            expected      <= '0;
        end else if (clr) begin
            word_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            mismatch      <= 1'b0;
            expected      <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + CNT_W'(1);
            expected <= expected + DATA_W'(STEP);
            if (rd_data != expected) begin
                if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
                if (!mismatch) begin
                    first_err_idx <= word_cnt;
                    mismatch      <= 1'b1;
                end
            end
        end
    end

    // A pop in the handshake cycle reloads the register directly, so there is no bubble
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            out_data  <= rd_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_consumer.sv
// Bench for fifo_rd_consumer: queue-based FIFO model feeds the DUT, forwarded words are scoreboarded.
module tb_fifo_rd_consumer;

    localparam int DATA_W    = 8;
    localparam int STEP      = 4;
    localparam int NUM_WORDS = 128;
    localparam int CNT_W     = 8;

    logic              clk_rd;
    logic              rst_n;
    logic              start;
    logic              rd_empty;
    logic [DATA_W-1:0] rd_data;
    logic              rd_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  first_err_idx;
    logic              mismatch;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              gap;
    logic              pop_pend;
    int                pop_cnt;
    int                n_cmp;
    int                n_err;

    fifo_rd_consumer #(
        .DATA_W(DATA_W), .STEP(STEP), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)
    ) dut (
        .clk_rd(clk_rd), .rst_n(rst_n), .start(start),
        .rd_empty(rd_empty), .rd_data(rd_data), .rd_en(rd_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .word_cnt(word_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .mismatch(mismatch)
    );

    initial clk_rd = 1'b0;
    always #5 clk_rd = ~clk_rd;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic refresh();
        rd_empty = gap || (fifo_q.size() == 0);
        rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk_rd);
        #2;
    endtask

    // FIFO model: the read pointer advances on edges where rd_en was high
    always @(negedge clk_rd) pop_pend = rd_en;

    always @(posedge clk_rd) begin
        #1;
        if (pop_pend && rst_n) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            else check("pop_while_empty", 1, 0);
        end
        refresh();
    end

    // Scoreboard monitor: compares each accepted output word against the queued expectation
    always @(negedge clk_rd) begin
        logic [DATA_W-1:0] e;
        if (rd_en) pop_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", int'(out_data), -1);
            end else begin
                e = exp_q.pop_front();
                check("out_word", int'(out_data), int'(e));
            end
        end
    end

    task automatic fill(input int bad_a, input int val_a, input int bad_b, input int val_b);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w = DATA_W'(i * STEP);
            if (i == bad_a) w = DATA_W'(val_a);
            if (i == bad_b) w = DATA_W'(val_b);
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        refresh();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 400) begin
            tick();
            k++;
        end
        check("done_reached", int'(done), 1);
    endtask

    initial begin
        int k;
        int base;
        logic [CNT_W-1:0] wc;
        logic             p;

        n_cmp = 0; n_err = 0; pop_cnt = 0;
        rst_n = 1'b1; start = 1'b0; out_ready = 1'b1; gap = 1'b0;
        refresh();
        #1 rst_n = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_word_cnt", int'(word_cnt), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_first_err", int'(first_err_idx), 0);
        check("rst_mismatch", int'(mismatch), 0);
        rst_n = 1'b1;
        tick();

        // clean stream: 128 pops on consecutive cycles
        fill(-1, 0, -1, 0);
        base = pop_cnt;
        pulse_start();
        check("clean_busy", int'(busy), 1);
        wait_done(k);
        check("clean_cycles", k, NUM_WORDS);
        check("clean_pops", pop_cnt - base, NUM_WORDS);
        check("clean_word_cnt", int'(word_cnt), NUM_WORDS);
        check("clean_err_cnt", int'(err_cnt), 0);
        check("clean_mismatch", int'(mismatch), 0);
        check("clean_busy_end", int'(busy), 0);
        fifo_q.push_back(8'hAA);
        refresh();
        #1 check("done_rd_en0", int'(rd_en), 0);
        tick();
        #1 check("done_rd_en1", int'(rd_en), 0);
        check("done_word_cnt", int'(word_cnt), NUM_WORDS);
        fifo_q.delete();
        refresh();
        tick();
        check("clean_drained", exp_q.size(), 0);

        // corrupted words 5 and 9
        fill(5, 'h15, 9, 'h00);
        pulse_start();
        wait_done(k);
        check("corr_err_cnt", int'(err_cnt), 2);
        check("corr_first_err", int'(first_err_idx), 5);
        check("corr_mismatch", int'(mismatch), 1);
        check("corr_word_cnt", int'(word_cnt), NUM_WORDS);
        tick();
        check("corr_drained", exp_q.size(), 0);

        // backpressure: one pop, then stall, then pop+handshake in one cycle
        out_ready = 1'b0;
        fill(-1, 0, -1, 0);
        base = pop_cnt;
        pulse_start();
        #1 check("bp_rd_en_first", int'(rd_en), 1);
        check("bp_mismatch_clr", int'(mismatch), 0);
        tick();
        #1 check("bp_valid", int'(out_valid), 1);
        check("bp_data0", int'(out_data), 0);
        check("bp_rd_en_stall", int'(rd_en), 0);
        repeat (2) begin
            tick();
            #1 check("bp_hold_data", int'(out_data), 0);
            check("bp_hold_rd_en", int'(rd_en), 0);
            check("bp_hold_cnt", int'(word_cnt), 1);
        end
        check("bp_single_pop", pop_cnt - base, 1);
        out_ready = 1'b1;
        #1 check("bp_rd_en_release", int'(rd_en), 1);
        tick();
        #1 check("bp_data1", int'(out_data), 4);
        check("bp_valid1", int'(out_valid), 1);
        check("bp_cnt2", int'(word_cnt), 2);
        wait_done(k);
        check("bp_err_cnt", int'(err_cnt), 0);
        tick();
        check("bp_drained", exp_q.size(), 0);

        // empty gaps every other cycle
        fill(-1, 0, -1, 0);
        pulse_start();
        k = 0;
        while (!done && k < 400) begin
            gap = ~gap;
            refresh();
            #1;
            if (rd_empty) check("gap_rd_en", int'(rd_en), 0);
            p  = rd_en;
            wc = word_cnt;
            tick();
            check("gap_word_cnt", int'(word_cnt), int'(CNT_W'(wc + CNT_W'(p))));
            k++;
        end
        gap = 1'b0;
        refresh();
        check("gap_done", int'(done), 1);
        check("gap_err_cnt", int'(err_cnt), 0);
        tick();
        check("gap_drained", exp_q.size(), 0);

        // start during RUN is ignored; reset mid-transfer aborts
        fill(-1, 0, -1, 0);
        pulse_start();
        repeat (10) tick();
        wc = word_cnt;
        pulse_start();
        #1 check("run_start_cnt", int'(word_cnt), int'(CNT_W'(wc + CNT_W'(1))));
        check("run_start_busy", int'(busy), 1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1 check("arst_valid", int'(out_valid), 0);
        check("arst_word_cnt", int'(word_cnt), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_rd_en", int'(rd_en), 0);
        check("arst_err_cnt", int'(err_cnt), 0);
        fifo_q.delete();
        exp_q.delete();
        refresh();
        tick();
        rst_n = 1'b1;
        tick();
        fill(-1, 0, -1, 0);
        pulse_start();
        wait_done(k);
        check("post_rst_err", int'(err_cnt), 0);
        check("post_rst_mismatch", int'(mismatch), 0);
        check("post_rst_cnt", int'(word_cnt), NUM_WORDS);
        tick();
        check("post_rst_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
